// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared address map, device indices, state encoding and defaults for the CPU I/O bus
package io_bus_pkg;

   localparam int DEFAULT_TIMEOUT = 15;
   localparam int NUM_DEV         = 4;
   localparam int DATA_W          = 16;

   // Each device owns one 16-byte page; these are addr[31:4] of that page.
   localparam logic [27:0] KEY_PAGE = 28'hFFFFFC1;
   localparam logic [27:0] SW_PAGE  = 28'hFFFFFC7;
   localparam logic [27:0] CTC_PAGE = 28'hFFFFFC2;
   localparam logic [27:0] LED_PAGE = 28'hFFFFFC6;

   localparam int DEV_KEY = 0;
   localparam int DEV_SW  = 1;
   localparam int DEV_CTC = 2;
   localparam int DEV_LED = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2,
      ST_ERR    = 2'd3
   } state_t;

   function automatic logic [1:0] sel_to_idx(input logic [NUM_DEV-1:0] sel);
      sel_to_idx = 2'd0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (sel[i]) sel_to_idx = 2'(i);
      end
   endfunction

endpackage

// File: rtl/io_addr_decode.sv
// rtl/io_addr_decode.sv - page decode to one-hot device select plus direction legality check
module io_addr_decode
   import io_bus_pkg::*;
(
   input  logic [31:4]        addr,
   input  logic               we,
   output logic [NUM_DEV-1:0] sel,
   output logic               legal
);

   // Select is reported even for a wrong direction; legal alone decides ACCESS vs ERR.
   always_comb begin
      sel   = '0;
      legal = 1'b0;
      case (addr)
         KEY_PAGE: begin sel[DEV_KEY] = 1'b1; legal = ~we;  end
         SW_PAGE:  begin sel[DEV_SW]  = 1'b1; legal = ~we;  end
         CTC_PAGE: begin sel[DEV_CTC] = 1'b1; legal = 1'b1; end
         LED_PAGE: begin sel[DEV_LED] = 1'b1; legal = we;   end
         default:  ;
      endcase
   end

endmodule

// File: rtl/io_bus_ctrl.sv
// rtl/io_bus_ctrl.sv - CPU I/O bus controller: decode, strobe a device, wait for ack or time out
module io_bus_ctrl
   import io_bus_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
)(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      req,
   input  logic                      we,
   input  logic [31:0]               addr,
   input  logic [DATA_W-1:0]         wdata,
   output logic [DATA_W-1:0]         rdata,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [NUM_DEV-1:0]        dev_sel,
   output logic                      dev_rd,
   output logic                      dev_wr,
   output logic [3:0]                dev_addr,
   output logic [DATA_W-1:0]         dev_wdata,
   input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
   input  logic [NUM_DEV-1:0]        dev_ack
);

   localparam int CNT_W = $clog2(TIMEOUT + 1) + 1;

   state_t             state, state_n;
   logic [NUM_DEV-1:0] dec_sel, sel_q;
   logic               dec_legal;
   logic               we_q;
   logic [1:0]         idx_q;
   logic [CNT_W-1:0]   cnt;
   logic               accept;
   logic               ack_sel;

   io_addr_decode u_decode (
      .addr  (addr[31:4]),
      .we    (we),
      .sel   (dec_sel),
      .legal (dec_legal)
   );

   assign accept  = (state == ST_IDLE) && req;
   assign ack_sel = |(dev_ack & sel_q);

   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_n;
   end

   // An ack in the timeout cycle takes priority over the error.
   always_comb begin
      state_n = state;
      busy    = 1'b1;
      done    = 1'b0;
      err     = 1'b0;
      dev_sel = '0;
      dev_rd  = 1'b0;
      dev_wr  = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (req) state_n = dec_legal ? ST_ACCESS : ST_ERR;
         end
         ST_ACCESS: begin
            dev_sel = sel_q;
            dev_rd  = ~we_q;
            dev_wr  = we_q;
            if (ack_sel)                         state_n = ST_DONE;
            else if (cnt == CNT_W'(TIMEOUT))     state_n = ST_ERR;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_n = ST_IDLE;
         end
         ST_ERR: begin
            done    = 1'b1;
            err     = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sel_q     <= '0;
         idx_q     <= 2'd0;
         we_q      <= 1'b0;
         dev_addr  <= 4'd0;
         dev_wdata <= '0;
         cnt       <= '0;
         rdata     <= '0;
      end else begin
         if (accept) begin
            sel_q     <= dec_sel;
            idx_q     <= sel_to_idx(dec_sel);
            we_q      <= we;
            dev_addr  <= addr[3:0];
            dev_wdata <= wdata;
            cnt       <= '0;
         end else if (state == ST_ACCESS) begin
            cnt <= cnt + 1'b1;
         end
         if ((state == ST_ACCESS) && ack_sel && !we_q)
            rdata <= dev_rdata[{idx_q, 4'b0000} +: DATA_W];
      end
   end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb/tb_io_bus_ctrl.sv - directed and randomized bench for io_bus_ctrl with a transaction-level reference model
module tb_io_bus_ctrl;

   localparam int TO = 15;

   logic        clock;
   logic        reset;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [3:0]  dev_sel;
   logic        dev_rd;
   logic        dev_wr;
   logic [3:0]  dev_addr;
   logic [15:0] dev_wdata;
   logic [63:0] dev_rdata;
   logic [3:0]  dev_ack;

   int checks = 0;
   int errors = 0;

   io_bus_ctrl #(.TIMEOUT(TO)) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .dev_sel   (dev_sel),
      .dev_rd    (dev_rd),
      .dev_wr    (dev_wr),
      .dev_addr  (dev_addr),
      .dev_wdata (dev_wdata),
      .dev_rdata (dev_rdata),
      .dev_ack   (dev_ack)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one pending access described by device, direction and cycles waited.
   // phase: 0 idle, 1 waiting for device, 2 finished ok, 3 finished with error
   int          m_phase = 0;
   int          m_dev   = -1;
   int          m_wait  = 0;
   logic        m_we    = 1'b0;
   logic [31:0] m_addr  = '0;
   logic [15:0] m_wdata = '0;
   logic [15:0] m_rdata = '0;
   bit          model_live = 1'b0;

   function automatic int model_dev(input logic [31:0] a);
      if (a >= 32'hFFFFFC10 && a <= 32'hFFFFFC1F) return 0;
      if (a >= 32'hFFFFFC70 && a <= 32'hFFFFFC7F) return 1;
      if (a >= 32'hFFFFFC20 && a <= 32'hFFFFFC2F) return 2;
      if (a >= 32'hFFFFFC60 && a <= 32'hFFFFFC6F) return 3;
      return -1;
   endfunction

   function automatic bit model_legal(input int d, input logic w);
      if (d < 0)  return 1'b0;
      if (d == 2) return 1'b1;
      if (d == 3) return w;
      return !w;
   endfunction

   initial begin
      forever begin
         @(posedge clock);
         if (reset) begin
            model_live = 1'b1;
            m_phase = 0; m_dev = -1; m_wait = 0; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
         end else begin
            case (m_phase)
               0: if (req) begin
                     m_addr  = addr;
                     m_wdata = wdata;
                     m_we    = we;
                     m_dev   = model_dev(addr);
                     m_wait  = 0;
                     m_phase = model_legal(m_dev, we) ? 1 : 3;
                  end
               1: begin
                     if (dev_ack[m_dev]) begin
                        if (!m_we) m_rdata = dev_rdata[m_dev*16 +: 16];
                        m_phase = 2;
                     end else if (m_wait == TO) begin
                        m_phase = 3;
                     end else begin
                        m_wait++;
                     end
                  end
               default: m_phase = 0;
            endcase
         end
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         if (model_live) begin
            chk("cmp_busy",      busy,      (m_phase != 0));
            chk("cmp_done",      done,      (m_phase >= 2));
            chk("cmp_err",       err,       (m_phase == 3));
            chk("cmp_dev_sel",   dev_sel,   (m_phase == 1) ? 4'(1 << m_dev) : 4'b0000);
            chk("cmp_dev_rd",    dev_rd,    (m_phase == 1) && !m_we);
            chk("cmp_dev_wr",    dev_wr,    (m_phase == 1) && m_we);
            chk("cmp_dev_addr",  dev_addr,  m_addr[3:0]);
            chk("cmp_dev_wdata", dev_wdata, m_wdata);
            chk("cmp_rdata",     rdata,     m_rdata);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic w, input logic [31:0] a, input logic [15:0] d);
      req = 1'b1; we = w; addr = a; wdata = d;
      tick();
      req = 1'b0;
   endtask

   function automatic logic [31:0] pick_addr();
      logic [31:0] mapped [4]   = '{32'hFFFFFC10, 32'hFFFFFC70, 32'hFFFFFC20, 32'hFFFFFC60};
      logic [31:0] unmapped [6] = '{32'hFFFFFC00, 32'hFFFFFC30, 32'hFFFFFC80,
                                    32'h00000C20, 32'hFFFFFD60, 32'h7FFFFC20};
      if ($urandom_range(0, 3) != 0)
         return mapped[$urandom_range(0, 3)] | 32'($urandom_range(0, 15));
      return unmapped[$urandom_range(0, 5)] | 32'($urandom_range(0, 15));
   endfunction

   initial begin
      int  acc;
      bit  quiet;
      reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      dev_rdata = '0; dev_ack = '0;
      repeat (2) tick();
      reset = 1'b0;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_sel", dev_sel, 4'b0000);
      chk("rst_strobes", {dev_rd, dev_wr}, 2'b00);
      chk("rst_rdata", rdata, 16'h0000);
      chk("rst_dev_addr", dev_addr, 4'h0);
      chk("rst_dev_wdata", dev_wdata, 16'h0000);

      // switch read, ack two cycles after the request
      issue(1'b0, 32'hFFFFFC70, 16'h0000);
      chk("sw_sel", dev_sel, 4'b0010);
      chk("sw_rd", dev_rd, 1'b1);
      chk("sw_busy", busy, 1'b1);
      tick();
      dev_ack = 4'b0010; dev_rdata = 64'h1111_2222_00A5_3333;
      tick();
      dev_ack = 4'b0000;
      chk("sw_done", done, 1'b1);
      chk("sw_err", err, 1'b0);
      chk("sw_rdata", rdata, 16'h00A5);
      chk("model_sw_rdata", m_rdata, 16'h00A5);
      chk("sw_sel_off", dev_sel, 4'b0000);
      tick();
      chk("sw_done_once", done, 1'b0);

      // LED write
      issue(1'b1, 32'hFFFFFC60, 16'h1234);
      chk("led_sel", dev_sel, 4'b1000);
      chk("led_wr", dev_wr, 1'b1);
      chk("led_rd", dev_rd, 1'b0);
      chk("led_wdata", dev_wdata, 16'h1234);
      repeat (2) tick();
      chk("led_wr_held", dev_wr, 1'b1);
      dev_ack = 4'b1000; dev_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      dev_ack = 4'b0000;
      chk("led_done", done, 1'b1);
      chk("led_rdata_kept", rdata, 16'h00A5);
      tick();

      // illegal direction and unmapped address
      issue(1'b1, 32'hFFFFFC10, 16'hBEEF);
      chk("key_wr_err", {done, err}, 2'b11);
      chk("key_wr_strobes", {dev_sel, dev_rd, dev_wr}, 6'b0);
      tick();
      issue(1'b0, 32'hFFFFFC00, 16'h0000);
      chk("unmap_err", {done, err}, 2'b11);
      chk("unmap_strobes", {dev_sel, dev_rd, dev_wr}, 6'b0);
      tick();
      chk("unmap_idle", busy, 1'b0);

      // CTC read that never gets an ack
      issue(1'b0, 32'hFFFFFC24, 16'h0000);
      acc = 0;
      while (dev_rd === 1'b1 && acc < 40) begin
         acc++;
         tick();
      end
      chk("to_access_cycles", acc, TO + 1);
      chk("to_err", {done, err}, 2'b11);
      chk("model_to_err", m_phase, 3);
      chk("to_rdata_kept", rdata, 16'h00A5);
      tick();

      // ack in the last counted cycle beats the timeout
      issue(1'b0, 32'hFFFFFC20, 16'h0000);
      repeat (TO) tick();
      chk("late_still_rd", dev_rd, 1'b1);
      dev_ack = 4'b0100; dev_rdata = 64'h0000_BEEF_0000_0000;
      tick();
      dev_ack = 4'b0000;
      chk("late_done", {done, err}, 2'b10);
      chk("late_rdata", rdata, 16'hBEEF);
      tick();

      // foreign ack and second request while busy are ignored
      issue(1'b0, 32'hFFFFFC20, 16'h0000);
      dev_ack = 4'b0001; req = 1'b1; we = 1'b1; addr = 32'hFFFFFC6B; wdata = 16'h5555;
      repeat (3) tick();
      chk("ign_sel", dev_sel, 4'b0100);
      chk("ign_busy", busy, 1'b1);
      chk("ign_addr", dev_addr, 4'h0);
      chk("ign_wdata", dev_wdata, 16'h0000);
      req = 1'b0; dev_ack = 4'b0101; dev_rdata = 64'h0000_4321_0000_0000;
      tick();
      dev_ack = 4'b0000;
      chk("ign_done", done, 1'b1);
      chk("ign_rdata", rdata, 16'h4321);
      tick();

      // reset in the middle of an access
      issue(1'b0, 32'hFFFFFC70, 16'h0000);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_strobes", {dev_sel, dev_rd, dev_wr}, 6'b0);
      chk("midrst_rdata", rdata, 16'h0000);
      chk("midrst_done", {done, busy}, 2'b00);
      tick();
      chk("midrst_no_done", done, 1'b0);

      // randomized traffic against the model
      quiet = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 99) < 3) quiet = ~quiet;
         req       = ($urandom_range(0, 2) == 0);
         we        = 1'($urandom_range(0, 1));
         addr      = pick_addr();
         wdata     = 16'($urandom);
         dev_ack   = quiet ? 4'b0000 : (4'($urandom) & 4'($urandom));
         dev_rdata = {$urandom, $urandom};
         reset     = ($urandom_range(0, 599) == 0);
         tick();
      end
      reset = 1'b0; req = 1'b0; dev_ack = 4'b0000;
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
